// File: rtl/gelato_split_table_pkg.sv
// Shared types for the Gelato SIMT split table: geometry, stack entries and counters.
// The geometry lives here so the interface, the stacks and the top agree on every width.
package gelato_split_table_pkg;

  localparam int NUM_WARPS   = 4;
  localparam int NUM_THREADS = 32;
  localparam int DEPTH       = 8;
  localparam int ADDR_WIDTH  = 32;

  localparam int WARP_W = $clog2(NUM_WARPS);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef logic [ADDR_WIDTH-1:0]  addr_t;
  typedef logic [NUM_THREADS-1:0] thread_mask_t;
  typedef logic [WARP_W-1:0]      warp_id_t;
  typedef logic [CNT_W-1:0]       split_table_num_t;

  typedef struct packed {
    addr_t        pc;
    thread_mask_t mask;
  } split_entry_t;

endpackage

// File: rtl/gelato_split_table_if.sv
// Branch-unit / scheduler side bundle of the split table: split and join requests,
// the registered response and the per-warp active masks.
interface gelato_split_table_if;
  import gelato_split_table_pkg::*;

  logic                             split_valid;
  logic                             split_ready;
  warp_id_t                         split_warp;
  thread_mask_t                     split_taken_mask;
  addr_t                            split_taken_pc;
  addr_t                            split_fall_pc;
  addr_t                            split_reconv_pc;
  logic                             join_valid;
  warp_id_t                         join_warp;
  addr_t                            join_pc;
  logic                             resp_valid;
  warp_id_t                         resp_warp;
  addr_t                            resp_pc;
  thread_mask_t                     resp_mask;
  logic [NUM_WARPS*NUM_THREADS-1:0] warp_mask;
  logic                             underflow;

  modport master (
    output split_valid, split_warp, split_taken_mask, split_taken_pc,
           split_fall_pc, split_reconv_pc, join_valid, join_warp, join_pc,
    input  split_ready, resp_valid, resp_warp, resp_pc, resp_mask,
           warp_mask, underflow
  );

  modport slave (
    input  split_valid, split_warp, split_taken_mask, split_taken_pc,
           split_fall_pc, split_reconv_pc, join_valid, join_warp, join_pc,
    output split_ready, resp_valid, resp_warp, resp_pc, resp_mask,
           warp_mask, underflow
  );

endinterface

// File: rtl/gelato_split_stack.sv
// One warp's reconvergence stack: LIFO of {pc, mask} entries, an occupancy count
// and the warp's current active thread mask.
module gelato_split_stack
  import gelato_split_table_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push2,
  input  logic             pop,
  input  split_entry_t     push_lo,
  input  split_entry_t     push_hi,
  input  logic             mask_we,
  input  thread_mask_t     mask_d,
  output split_entry_t     top,
  output split_table_num_t count,
  output thread_mask_t     active_mask
);

  localparam int IDX_W = $clog2(DEPTH);

  split_entry_t     entries [DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  assign wr_idx  = IDX_W'(count);
  assign top_idx = IDX_W'(count - 1'b1);
  assign top     = (count == '0) ? '0 : entries[top_idx];

  // Entry storage is only meaningful below count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push2) begin
      entries[wr_idx]        <= push_lo;
      entries[wr_idx + 1'b1] <= push_hi;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      active_mask <= '1;
    end else begin
      if (push2) begin
        count <= count + CNT_W'(2);
      end else if (pop) begin
        count <= count - 1'b1;
      end
      if (mask_we) begin
        active_mask <= mask_d;
      end
    end
  end

endmodule

// File: rtl/gelato_split_table.sv
// Per-warp SIMT divergence/reconvergence table: decodes split/join requests onto the
// per-warp stacks and returns the next PC and active mask one cycle later.
module gelato_split_table
  import gelato_split_table_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  gelato_split_table_if.slave bus
);

  thread_mask_t     active  [NUM_WARPS];
  split_table_num_t count   [NUM_WARPS];
  split_entry_t     top     [NUM_WARPS];
  thread_mask_t     mask_d  [NUM_WARPS];
  logic [NUM_WARPS-1:0] push2;
  logic [NUM_WARPS-1:0] pop;
  logic [NUM_WARPS-1:0] mask_we;
  logic [NUM_WARPS*NUM_THREADS-1:0] warp_mask_flat;

  thread_mask_t split_a;
  thread_mask_t split_t;
  thread_mask_t split_f;
  logic         split_fire;
  logic         split_divergent;
  logic         join_empty;
  split_entry_t reconv_entry;
  split_entry_t fall_entry;

  assign split_a         = active[bus.split_warp];
  assign split_t         = bus.split_taken_mask & split_a;
  assign split_f         = split_a & ~split_t;
  assign split_divergent = (split_t != '0) && (split_f != '0);

  // A divergent split needs two free slots; joins always win the cycle.
  assign bus.split_ready = !bus.join_valid &&
                           (count[bus.split_warp] <= split_table_num_t'(DEPTH - 2));
  assign split_fire      = bus.split_valid && bus.split_ready;
  assign join_empty      = (count[bus.join_warp] == '0);

  assign reconv_entry = '{pc: bus.split_reconv_pc, mask: split_a};
  assign fall_entry   = '{pc: bus.split_fall_pc,   mask: split_f};

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    assign push2[w]   = split_fire && split_divergent && (bus.split_warp == warp_id_t'(w));
    assign pop[w]     = bus.join_valid && !join_empty && (bus.join_warp == warp_id_t'(w));
    assign mask_we[w] = push2[w] | pop[w];
    assign mask_d[w]  = push2[w] ? split_t : top[w].mask;

    gelato_split_stack u_stack (
      .clk         (clk),
      .rst         (rst),
      .push2       (push2[w]),
      .pop         (pop[w]),
      .push_lo     (reconv_entry),
      .push_hi     (fall_entry),
      .mask_we     (mask_we[w]),
      .mask_d      (mask_d[w]),
      .top         (top[w]),
      .count       (count[w]),
      .active_mask (active[w])
    );
  end

  always_comb begin
    warp_mask_flat = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      warp_mask_flat[w*NUM_THREADS +: NUM_THREADS] = active[w];
    end
  end

  assign bus.warp_mask = warp_mask_flat;

  // Response register: a non-empty join returns the popped entry, an empty join echoes
  // join_pc with the current mask; a uniform split keeps the whole active mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.resp_valid <= 1'b0;
      bus.resp_warp  <= '0;
      bus.resp_pc    <= '0;
      bus.resp_mask  <= '0;
      bus.underflow  <= 1'b0;
    end else begin
      bus.resp_valid <= bus.join_valid || split_fire;
      bus.underflow  <= bus.join_valid && join_empty;
      if (bus.join_valid) begin
        bus.resp_warp <= bus.join_warp;
        if (join_empty) begin
          bus.resp_pc   <= bus.join_pc;
          bus.resp_mask <= active[bus.join_warp];
        end else begin
          bus.resp_pc   <= top[bus.join_warp].pc;
          bus.resp_mask <= top[bus.join_warp].mask;
        end
      end else if (split_fire) begin
        bus.resp_warp <= bus.split_warp;
        bus.resp_pc   <= (split_t == '0) ? bus.split_fall_pc : bus.split_taken_pc;
        bus.resp_mask <= split_divergent ? split_t : split_a;
      end
    end
  end

endmodule

// File: tb/tb_gelato_split_table.sv
// Self-checking bench for gelato_split_table: table-driven vectors plus hand-written
// nesting, collision and reset sequences, checked against a reference stack model.
module tb_gelato_split_table;
  import gelato_split_table_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gelato_split_table_if bus ();

  gelato_split_table dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    warp_id_t     warp;
    addr_t        pc;
    thread_mask_t mask;
    logic         uf;
  } exp_t;

  typedef struct {
    logic         sv;
    int           sw;
    thread_mask_t tm;
    addr_t        tpc;
    addr_t        fpc;
    addr_t        rpc;
    logic         jv;
    int           jw;
    addr_t        jpc;
    logic         ev;
    addr_t        epc;
    thread_mask_t emask;
    logic         euf;
  } vec_t;

  addr_t        m_pc  [NUM_WARPS][DEPTH];
  thread_mask_t m_msk [NUM_WARPS][DEPTH];
  int           m_cnt [NUM_WARPS];
  thread_mask_t m_act [NUM_WARPS];
  exp_t         sb [$];
  int           checks = 0;
  int           fails  = 0;
  vec_t         vecs [7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic modelReset();
    for (int w = 0; w < NUM_WARPS; w++) begin
      m_cnt[w] = 0;
      m_act[w] = '1;
    end
    sb.delete();
  endtask

  function automatic logic [NUM_WARPS*NUM_THREADS-1:0] modelWarpMask();
    logic [NUM_WARPS*NUM_THREADS-1:0] r;
    for (int w = 0; w < NUM_WARPS; w++) r[w*NUM_THREADS +: NUM_THREADS] = m_act[w];
    return r;
  endfunction

  // Drives one cycle of requests, predicts the outcome and advances to edge+1.
  task automatic applyStimulus(input logic sv, input int sw, input thread_mask_t tm,
                               input addr_t tpc, input addr_t fpc, input addr_t rpc,
                               input logic jv, input int jw, input addr_t jpc);
    exp_t e;
    logic ready;
    thread_mask_t a, t, f;
    bus.split_valid      = sv;
    bus.split_warp       = warp_id_t'(sw);
    bus.split_taken_mask = tm;
    bus.split_taken_pc   = tpc;
    bus.split_fall_pc    = fpc;
    bus.split_reconv_pc  = rpc;
    bus.join_valid       = jv;
    bus.join_warp        = warp_id_t'(jw);
    bus.join_pc          = jpc;
    #1;
    ready = !jv && (m_cnt[sw] <= DEPTH - 2);
    check("split_ready", bus.split_ready, ready);
    if (jv) begin
      e.warp = warp_id_t'(jw);
      e.uf   = (m_cnt[jw] == 0);
      if (e.uf) begin
        e.pc   = jpc;
        e.mask = m_act[jw];
      end else begin
        m_cnt[jw]--;
        e.pc      = m_pc[jw][m_cnt[jw]];
        e.mask    = m_msk[jw][m_cnt[jw]];
        m_act[jw] = e.mask;
      end
      sb.push_back(e);
    end else if (sv && ready) begin
      a = m_act[sw];
      t = tm & a;
      f = a & ~t;
      e.warp = warp_id_t'(sw);
      e.uf   = 1'b0;
      if (t == '0) begin
        e.pc = fpc; e.mask = a;
      end else if (f == '0) begin
        e.pc = tpc; e.mask = a;
      end else begin
        m_pc[sw][m_cnt[sw]] = rpc; m_msk[sw][m_cnt[sw]] = a; m_cnt[sw]++;
        m_pc[sw][m_cnt[sw]] = fpc; m_msk[sw][m_cnt[sw]] = f; m_cnt[sw]++;
        e.pc = tpc; e.mask = t;
        m_act[sw] = t;
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.split_valid = 1'b0;
    bus.join_valid  = 1'b0;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("resp_valid", bus.resp_valid, 1'b1);
      check("resp_warp",  bus.resp_warp,  e.warp);
      check("resp_pc",    bus.resp_pc,    e.pc);
      check("resp_mask",  bus.resp_mask,  e.mask);
      check("underflow",  bus.underflow,  e.uf);
    end else begin
      check("resp_valid idle", bus.resp_valid, 1'b0);
      check("underflow idle",  bus.underflow,  1'b0);
    end
    check("warp_mask", bus.warp_mask, modelWarpMask());
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.split_valid = 1'b0; bus.split_warp = '0; bus.split_taken_mask = '0;
    bus.split_taken_pc = '0; bus.split_fall_pc = '0; bus.split_reconv_pc = '0;
    bus.join_valid = 1'b0; bus.join_warp = '0; bus.join_pc = '0;
    rst = 1'b1;
    modelReset();

    #2;
    check("reset warp_mask",  bus.warp_mask,  {(NUM_WARPS*NUM_THREADS){1'b1}});
    check("reset resp_valid", bus.resp_valid, 1'b0);
    check("reset resp_pc",    bus.resp_pc,    32'h0);
    check("reset resp_mask",  bus.resp_mask,  32'h0);
    check("reset underflow",  bus.underflow,  1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("reset split_ready", bus.split_ready, 1'b1);

    //              sv  sw  taken_mask     tpc       fpc       rpc       jv  jw  jpc       ev  epc       emask          euf
    vecs[0] = '{1'b1, 1, 32'hFFFFFFFF, 32'h100, 32'h104, 32'h300, 1'b0, 0, 32'h0,   1'b1, 32'h100, 32'hFFFFFFFF, 1'b0};
    vecs[1] = '{1'b1, 0, 32'h0000FFFF, 32'h200, 32'h104, 32'h300, 1'b0, 0, 32'h0,   1'b1, 32'h200, 32'h0000FFFF, 1'b0};
    vecs[2] = '{1'b0, 0, 32'h0,        32'h0,   32'h0,   32'h0,   1'b1, 0, 32'h500, 1'b1, 32'h104, 32'hFFFF0000, 1'b0};
    vecs[3] = '{1'b0, 0, 32'h0,        32'h0,   32'h0,   32'h0,   1'b1, 0, 32'h500, 1'b1, 32'h300, 32'hFFFFFFFF, 1'b0};
    vecs[4] = '{1'b0, 0, 32'h0,        32'h0,   32'h0,   32'h0,   1'b1, 1, 32'h40,  1'b1, 32'h40,  32'hFFFFFFFF, 1'b1};
    vecs[5] = '{1'b1, 3, 32'h0,        32'h600, 32'h604, 32'h700, 1'b0, 0, 32'h0,   1'b1, 32'h604, 32'hFFFFFFFF, 1'b0};
    vecs[6] = '{1'b0, 0, 32'h0,        32'h0,   32'h0,   32'h0,   1'b0, 0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b0};

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].sv, vecs[i].sw, vecs[i].tm, vecs[i].tpc, vecs[i].fpc, vecs[i].rpc,
                    vecs[i].jv, vecs[i].jw, vecs[i].jpc);
      check($sformatf("vec%0d valid", i), bus.resp_valid, vecs[i].ev);
      check($sformatf("vec%0d underflow", i), bus.underflow, vecs[i].euf);
      if (vecs[i].ev) begin
        check($sformatf("vec%0d pc", i),   bus.resp_pc,   vecs[i].epc);
        check($sformatf("vec%0d mask", i), bus.resp_mask, vecs[i].emask);
      end
      checkOutput();
    end

    $display("[TB] nested splits on warp 2");
    applyStimulus(1'b1, 2, 32'h0000FFFF, 32'h1000, 32'h1004, 32'h1100, 1'b0, 0, 32'h0); checkOutput();
    applyStimulus(1'b1, 2, 32'h000000FF, 32'h2000, 32'h2004, 32'h2100, 1'b0, 0, 32'h0); checkOutput();
    applyStimulus(1'b1, 2, 32'h0000000F, 32'h3000, 32'h3004, 32'h3100, 1'b0, 0, 32'h0); checkOutput();
    applyStimulus(1'b0, 0, 32'h0,        32'h0,    32'h0,    32'h0,    1'b1, 2, 32'h0); checkOutput();
    applyStimulus(1'b1, 2, 32'h00000030, 32'h4000, 32'h4004, 32'h4100, 1'b0, 0, 32'h0); checkOutput();
    bus.split_valid = 1'b1; bus.split_warp = 2'd2;
    #1;
    check("nest full ready", bus.split_ready, 1'b0);
    applyStimulus(1'b1, 2, 32'h00000010, 32'h5000, 32'h5004, 32'h5100, 1'b0, 0, 32'h0); checkOutput();
    applyStimulus(1'b0, 0, 32'h0,        32'h0,    32'h0,    32'h0,    1'b1, 2, 32'h0); checkOutput();
    bus.split_valid = 1'b1; bus.split_warp = 2'd2;
    #1;
    check("nest reopen ready", bus.split_ready, 1'b1);
    bus.split_valid = 1'b0;

    $display("[TB] split and join collide");
    applyStimulus(1'b1, 0, 32'h00FF00FF, 32'h800, 32'h804, 32'h900, 1'b1, 3, 32'h700); checkOutput();
    applyStimulus(1'b1, 0, 32'h00FF00FF, 32'h800, 32'h804, 32'h900, 1'b0, 0, 32'h0);   checkOutput();

    $display("[TB] reset mid-nesting");
    rst = 1'b1;
    #2;
    check("midreset warp_mask",  bus.warp_mask,  {(NUM_WARPS*NUM_THREADS){1'b1}});
    check("midreset resp_valid", bus.resp_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    modelReset();
    applyStimulus(1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2, 32'hA00); checkOutput();
    applyStimulus(1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 0, 32'hB00); checkOutput();
    applyStimulus(1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 32'h0);   checkOutput();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
